// File: rtl/data_mem_be.sv
// rtl/data_mem_be.sv - byte-enable word RAM with registered reads, range check and post-reset clear engine
// Optional build macro: DATAMEM_ALIGN_CHK_EN (reject accesses whose addr[1:0] != 0)

module data_mem_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int RAM_SIZE     = 256,
  parameter int RAM_SIZE_BIT = 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rd,
  input  logic                    wr,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid,
  output logic                    busy,
  output logic                    err
);

  localparam int NUM_LANES = DATA_WIDTH / 8;

`ifdef DATAMEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state;
  logic [RAM_SIZE_BIT-1:0] clr_ptr;
  logic [DATA_WIDTH-1:0]   mem [RAM_SIZE];

  logic [RAM_SIZE_BIT-1:0] idx;
  logic                    out_of_range;
  logic                    misalign;
  logic                    reject;
  logic                    accept;
  logic                    wr_ok;
  logic                    clearing;
  logic                    last_clr;

  // Address decode and request qualification; requests only count in IDLE
  always_comb begin
    idx          = addr[RAM_SIZE_BIT+1:2];
    out_of_range = |addr[31:RAM_SIZE_BIT+2];
    misalign     = ALIGN_CHK && (addr[1:0] != 2'b00);
    reject       = out_of_range | misalign;
    accept       = (state == ST_IDLE);
    wr_ok        = accept & wr & ~reject;
    clearing     = (state == ST_CLEAR);
    last_clr     = (clr_ptr == RAM_SIZE_BIT'(RAM_SIZE - 1));
  end

  // Array write port: clear engine has priority, otherwise lane-masked CPU writes
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clearing) begin
        mem[clr_ptr] <= '0;
      end else if (wr_ok) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (be[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Control FSM with registered outputs; the read samples the array before this
  // cycle's write lands, which gives read-before-write on a same-index rd+wr
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
      err     <= 1'b0;
      busy    <= (CLEAR_ON_RST != 0);
    end else begin
      case (state)
        ST_CLEAR: begin
          rvalid <= 1'b0;
          err    <= 1'b0;
          if (last_clr) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            clr_ptr <= '0;
          end else begin
            busy    <= 1'b1;
            clr_ptr <= clr_ptr + RAM_SIZE_BIT'(1);
          end
        end
        ST_IDLE: begin
          busy   <= 1'b0;
          rvalid <= rd;
          err    <= (rd | wr) & reject;
          if (rd) begin
            rdata <= reject ? '0 : mem[idx];
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rvalid <= 1'b0;
          err    <= 1'b0;
        end
      endcase
    end
  end

endmodule
